// File: rtl/approx_mul_pkg.sv
// -----------------------------------------------------------------------------
// approx_mul_pkg
// Shared declarations for the approximate-multiplier characterisation blocks.
//   sweep_state_t : FSM states of the operand sweeper
//   prod_w(w)     : product width for w-bit operands
//   cnt_w(w)      : error-count width (holds up to 2^(2w) pairs)
//   sum_w(w)      : error-sum width (never saturates over a full sweep)
// -----------------------------------------------------------------------------
package approx_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sweep_state_t;

   function automatic int prod_w(input int w);
      return 32'sd2 * w;
   endfunction

   function automatic int cnt_w(input int w);
      return (32'sd2 * w) + 32'sd1;
   endfunction

   function automatic int sum_w(input int w);
      return 32'sd4 * w;
   endfunction

endpackage

// File: rtl/if_multiplier.sv
// -----------------------------------------------------------------------------
// if_multiplier
// Connection between a WIDTH x WIDTH unsigned multiplier and whoever drives it.
//   in1, in2  : operands
//   out       : 2*WIDTH-bit product
//   overflow  : multiplier-reported overflow flag
//   drv_side  : operand driver (drives in1/in2, observes out/overflow)
//   mul_side  : the multiplier itself
// -----------------------------------------------------------------------------
interface if_multiplier #(
   parameter int WIDTH = 6
);
   logic [WIDTH-1:0]   in1;
   logic [WIDTH-1:0]   in2;
   logic [2*WIDTH-1:0] out;
   logic               overflow;

   modport drv_side (output in1, output in2, input out, input overflow);
   modport mul_side (input in1, input in2, output out, output overflow);
endinterface

// File: rtl/mul_err_sweeper_accum.sv
// -----------------------------------------------------------------------------
// err_accum
// Compares a returned product against the exact product of the operands and
// accumulates error statistics.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of all accumulators
//   en         : accumulate the current operand/product set this cycle
//   in1, in2   : operands currently on the multiplier bus
//   prod       : product returned by the multiplier under test
//   err_cnt    : number of mismatching pairs
//   err_max    : largest absolute error
//   err_sum    : sum of absolute errors
// -----------------------------------------------------------------------------
module err_accum
   import approx_mul_pkg::*;
#(
   parameter int WIDTH = 6
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       en,
   input  logic [WIDTH-1:0]           in1,
   input  logic [WIDTH-1:0]           in2,
   input  logic [prod_w(WIDTH)-1:0]   prod,
   output logic [cnt_w(WIDTH)-1:0]    err_cnt,
   output logic [prod_w(WIDTH)-1:0]   err_max,
   output logic [sum_w(WIDTH)-1:0]    err_sum
);
   localparam int PW = prod_w(WIDTH);
   localparam int CW = cnt_w(WIDTH);
   localparam int SW = sum_w(WIDTH);

   logic [PW-1:0] exact_s;
   logic [PW-1:0] diff_s;

   // Exact product and absolute difference against the returned product.
   always_comb begin
      exact_s = {{WIDTH{1'b0}}, in1} * {{WIDTH{1'b0}}, in2};
      if (prod >= exact_s) begin
         diff_s = prod - exact_s;
      end else begin
         diff_s = exact_s - prod;
      end
   end

   // Error count / max / sum registers; a zero difference leaves them untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= {CW{1'b0}};
         err_max <= {PW{1'b0}};
         err_sum <= {SW{1'b0}};
      end else if (clr) begin
         err_cnt <= {CW{1'b0}};
         err_max <= {PW{1'b0}};
         err_sum <= {SW{1'b0}};
      end else if (en && (diff_s != {PW{1'b0}})) begin
         err_cnt <= err_cnt + {{(CW-1){1'b0}}, 1'b1};
         err_sum <= err_sum + {{(SW-PW){1'b0}}, diff_s};
         if (diff_s > err_max) begin
            err_max <= diff_s;
         end
      end
   end

endmodule

// File: rtl/mul_err_sweeper.sv
// -----------------------------------------------------------------------------
// mul_err_sweeper
// Walks every operand pair of an attached combinational WIDTH x WIDTH multiplier
// (in1 fastest) and accumulates error metrics against the exact product.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a sweep (accepted only in IDLE)
//   abort      : stop a running sweep, keep partial results; wins over start
//   muif       : multiplier bus (drives operands, samples out/overflow)
//   busy       : sweep in progress
//   done       : one-cycle pulse after the last pair has been accumulated
//   err_cnt    : mismatching pairs
//   err_max    : largest |out - exact|
//   err_sum    : sum of |out - exact|
//   ovf_seen   : overflow reported on any sampled pair (sticky per sweep)
// -----------------------------------------------------------------------------
module mul_err_sweeper
   import approx_mul_pkg::*;
#(
   parameter int WIDTH = 6
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       abort,
   if_multiplier.drv_side             muif,
   output logic                       busy,
   output logic                       done,
   output logic [cnt_w(WIDTH)-1:0]    err_cnt,
   output logic [prod_w(WIDTH)-1:0]   err_max,
   output logic [sum_w(WIDTH)-1:0]    err_sum,
   output logic                       ovf_seen
);
   localparam int IW = 2 * WIDTH;

   sweep_state_t  state_r;
   logic [IW-1:0] idx_r;
   logic          clr_s;
   logic          en_s;

   // The operand registers are the two halves of the pair counter.
   assign muif.in1 = idx_r[WIDTH-1:0];
   assign muif.in2 = idx_r[IW-1:WIDTH];

   // Accumulate on every RUN cycle (including an abort cycle, whose pair is on the bus).
   always_comb begin
      clr_s = (state_r == IDLE) && start && !abort;
      en_s  = (state_r == RUN);
   end

   // Sweep FSM, pair counter and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         idx_r    <= {IW{1'b0}};
         busy     <= 1'b0;
         done     <= 1'b0;
         ovf_seen <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (start && !abort) begin
                  state_r  <= RUN;
                  idx_r    <= {IW{1'b0}};
                  busy     <= 1'b1;
                  ovf_seen <= 1'b0;
               end else begin
                  busy <= 1'b0;
               end
            end
            RUN: begin
               ovf_seen <= ovf_seen | muif.overflow;
               idx_r    <= idx_r + {{(IW-1){1'b0}}, 1'b1};
               if (abort) begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b0;
               end else if (idx_r == {IW{1'b1}}) begin
                  // Completion is decided on the last pair, not on counter wrap.
                  state_r <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  busy <= 1'b1;
                  done <= 1'b0;
               end
            end
            DONE: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

   err_accum #(
      .WIDTH (WIDTH)
   ) u_err_accum (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr_s),
      .en      (en_s),
      .in1     (idx_r[WIDTH-1:0]),
      .in2     (idx_r[IW-1:WIDTH]),
      .prod    (muif.out),
      .err_cnt (err_cnt),
      .err_max (err_max),
      .err_sum (err_sum)
   );

endmodule
